// File: rtl/vgpr_wr_port_arbiter.sv
// Round-robin arbiter granting the single VGPR write port to one of 8 SIMD/SIMF requesters,
// with bounded burst ownership. Optional performance counters are enabled by VGPR_WR_ARB_PERF_EN.
module vgpr_wr_port_arbiter #(
    parameter int MAX_BEATS = 4  // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  wr_req,
    input  logic [7:0]  wr_last,
    input  logic        perf_clr,
    output logic [15:0] wr_port_select,
    output logic        arb_err,
    output logic [15:0] busy_cnt,
    output logic [15:0] conflict_cnt
);

    localparam int NUM_REQ = 8;
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BEATS - 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t              state;
    logic [2:0]          own;
    logic [2:0]          ptr;
    logic [3:0]          beat;
    logic [NUM_REQ-1:0]  sel_q;

    logic                own_req;
    logic                own_last;
    logic                at_limit;
    logic                release_now;
    logic                force_rel;
    logic                arbitrate;
    logic                any_req;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]  rot_req;
    logic [2:0]          rot_idx;
    logic [2:0]          winner;

    // Lowest set bit of a vector; the caller rotates so bit 0 is the highest-priority slot.
    function automatic logic [2:0] first_set(input logic [NUM_REQ-1:0] v);
        first_set = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (v[j]) first_set = 3'(j);
        end
    endfunction

    assign own_req  = wr_req[own];
    assign own_last = wr_last[own];
    assign at_limit = (beat == LAST_BEAT);

    // wr_last and abort take precedence over the beat limit, so only a true overrun flags an error.
    assign release_now = (state == OWNED) && (own_last || !own_req || at_limit);
    assign force_rel   = (state == OWNED) && own_req && !own_last && at_limit;
    assign arbitrate   = (state == IDLE) || release_now;

    assign req_dbl = {wr_req, wr_req};
    assign rot_req = req_dbl[ptr +: NUM_REQ];
    assign any_req = |wr_req;
    assign rot_idx = first_set(rot_req);
    assign winner  = ptr + rot_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            own     <= '0;
            ptr     <= '0;
            beat    <= '0;
            sel_q   <= '0;
            arb_err <= 1'b0;
        end else begin
            arb_err <= force_rel;
            if (arbitrate) begin
                beat <= '0;
                if (any_req) begin
                    state <= OWNED;
                    own   <= winner;
                    ptr   <= winner + 3'd1;
                    sel_q <= NUM_REQ'(1) << winner;
                end else begin
                    state <= IDLE;
                    sel_q <= '0;
                end
            end else begin
                beat <= beat + 4'd1;
            end
        end
    end

    assign wr_port_select = {8'h00, sel_q};

`ifdef VGPR_WR_ARB_PERF_EN
    logic busy_hit;
    logic conflict_hit;

    assign busy_hit     = |sel_q;
    assign conflict_hit = |(wr_req & ~sel_q);

    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            busy_cnt     <= '0;
            conflict_cnt <= '0;
        end else begin
            if (busy_hit && busy_cnt != 16'hFFFF)
                busy_cnt <= busy_cnt + 16'd1;
            if (conflict_hit && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`else
    logic perf_unused;

    assign perf_unused  = perf_clr;
    assign busy_cnt     = '0;
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_vgpr_wr_port_arbiter.sv
// Scoreboard bench: the driver advances a behavioural arbiter model and queues the expected
// post-edge outputs; an independent monitor pops and compares them every cycle.
module tb_vgpr_wr_port_arbiter;

    localparam int MAXB = 4;
`ifdef VGPR_WR_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  wr_req;
    logic [7:0]  wr_last;
    logic        perf_clr;
    logic [15:0] wr_port_select;
    logic        arb_err;
    logic [15:0] busy_cnt;
    logic [15:0] conflict_cnt;

    always #5 clk = ~clk;

    vgpr_wr_port_arbiter #(.MAX_BEATS(MAXB)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_last(wr_last), .perf_clr(perf_clr),
        .wr_port_select(wr_port_select), .arb_err(arb_err),
        .busy_cnt(busy_cnt), .conflict_cnt(conflict_cnt)
    );

    typedef struct {
        int sel;
        int err;
        int busy;
        int conf;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // Reference model: owner as integer (-1 = nobody), beats already held, priority start slot.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    int m_err   = 0;
    int m_busy  = 0;
    int m_conf  = 0;

    task automatic model_step(input logic r, input logic [7:0] q, input logic [7:0] l,
                              input logic c);
        bit rel;
        int w;
        exp_t e;
        if (r) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_err = 0; m_busy = 0; m_conf = 0;
        end else begin
            if (PERF) begin
                if (c) begin
                    m_busy = 0; m_conf = 0;
                end else begin
                    if (m_owner >= 0 && m_busy < 65535) m_busy++;
                    for (int k = 0; k < 8; k++) begin
                        if (q[k] && k != m_owner) begin
                            if (m_conf < 65535) m_conf++;
                            break;
                        end
                    end
                end
            end
            rel = 1'b1;
            m_err = 0;
            if (m_owner >= 0) begin
                if (!q[m_owner] || l[m_owner]) rel = 1'b1;
                else if (m_held == MAXB - 1) begin rel = 1'b1; m_err = 1; end
                else rel = 1'b0;
            end
            if (rel) begin
                w = -1;
                for (int k = 0; k < 8; k++) begin
                    if (w < 0 && q[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
                end
                m_owner = w;
                m_held  = 0;
                if (w >= 0) m_ptr = (w + 1) % 8;
            end else begin
                m_held++;
            end
        end
        e.sel  = (m_owner >= 0) ? (1 << m_owner) : 0;
        e.err  = m_err;
        e.busy = m_busy;
        e.conf = m_conf;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [7:0] q, input logic [7:0] l, input logic c);
        @(negedge clk);
        rst = r; wr_req = q; wr_last = l; perf_clr = c;
        model_step(r, q, l, c);
    endtask

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("select", int'(wr_port_select), e.sel);
                check("arb_err", int'(arb_err), e.err);
                check("busy_cnt", int'(busy_cnt), e.busy);
                check("conflict_cnt", int'(conflict_cnt), e.conf);
                check("onehot", ($countones(wr_port_select) > 1) ? 1 : 0, 0);
            end
        end
    end

    initial begin : stim
        logic [7:0] mask;
        logic [7:0] lst;
        int last_pct;
        rst = 1'b1; wr_req = '0; wr_last = '0; perf_clr = 1'b0;
        drive(1, 8'h00, 8'h00, 0);
        drive(1, 8'h00, 8'h00, 0);

        // two-beat burst from requester 0
        drive(0, 8'h01, 8'h00, 0);
        drive(0, 8'h01, 8'h00, 0);
        drive(0, 8'h00, 8'h01, 0);
        repeat (2) drive(0, 8'h00, 8'h00, 0);

        // full rotation with single-beat writes
        drive(1, 8'h00, 8'h00, 0);
        repeat (10) drive(0, 8'hFF, 8'hFF, 0);
        drive(0, 8'h00, 8'h00, 0);

        // overrun -> force release and re-grant
        repeat (7) drive(0, 8'h04, 8'h00, 0);
        drive(0, 8'h00, 8'h00, 0);

        // reset mid-burst
        repeat (3) drive(0, 8'h08, 8'h00, 0);
        drive(1, 8'h09, 8'h00, 0);
        repeat (3) drive(0, 8'h09, 8'hFF, 0);

        // counter scenario then clear
        drive(1, 8'h00, 8'h00, 0);
        repeat (10) drive(0, 8'h03, 8'hFF, 0);
        drive(0, 8'h00, 8'h00, 1);
        repeat (2) drive(0, 8'h00, 8'h00, 0);

        // randomized traffic with varying burst lengths
        mask = 8'h00;
        last_pct = 30;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) mask = 8'($urandom) & 8'($urandom | $urandom);
            if ($urandom_range(0, 99) == 0) last_pct = $urandom_range(0, 80);
            lst = '0;
            for (int k = 0; k < 8; k++) lst[k] = ($urandom_range(0, 99) < last_pct);
            drive(($urandom_range(0, 299) == 0), mask, lst, ($urandom_range(0, 49) == 0));
        end
        repeat (3) drive(0, 8'h00, 8'h00, 0);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
